// File: rtl/fire4_squeeze_weight_sequencer.sv
// Address/tag sequencer for the 32-lane fire4_squeeze weight ROM bank.
// Sweeps k=0..KLEN-1 per pixel and emits valid/first/last/pixel tags aligned to rom_out.
module fire4_squeeze_weight_sequencer #(
  parameter int unsigned ADDR = 10,
  parameter int unsigned KLEN = 128,
  parameter int unsigned NPIX = 729,
  parameter int unsigned PW   = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_en,
  output logic [ADDR-1:0] o_rom_addr,
  output logic            o_out_valid,
  output logic            o_out_first,
  output logic            o_out_last,
  output logic [PW-1:0]   o_out_pixel,
  output logic            o_busy,
  output logic            o_done
);

  localparam logic [ADDR-1:0] K_LAST = ADDR'(KLEN - 1);
  localparam logic [PW-1:0]   P_LAST = PW'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ADDR-1:0] r_k;
  logic [PW-1:0]   r_p;
  logic [ADDR-1:0] r_held_addr;
  logic            r_valid;
  logic            r_first;
  logic            r_last;
  logic [PW-1:0]   r_pixel;
  logic            r_done;

  logic w_issue;
  logic w_k_end;
  logic w_p_end;

  assign w_issue = (r_state == S_RUN) && i_en;
  assign w_k_end = (r_k == K_LAST);
  assign w_p_end = (r_p == P_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort cancels any pass and blocks a same-cycle start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (i_en && w_k_end && w_p_end) w_state_nxt = S_FLUSH;
      S_FLUSH: if (i_en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  // Output decode: re-present held_addr whenever not issuing so rom_out stays stable
  always_comb begin
    o_rom_addr = r_held_addr;
    o_busy     = (r_state != S_IDLE);
    if (w_issue) o_rom_addr = r_k;
  end

  // Counters and tags, captured on the same edge the ROM captures the word
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_k         <= '0;
      r_p         <= '0;
      r_held_addr <= '0;
      r_valid     <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_pixel     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_FLUSH) && i_en;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k <= '0;
            r_p <= '0;
          end
        end
        S_RUN: begin
          if (i_en) begin
            r_held_addr <= r_k;
            r_valid     <= 1'b1;
            r_first     <= (r_k == '0);
            r_last      <= w_k_end;
            r_pixel     <= r_p;
            if (w_k_end) begin
              r_k <= '0;
              r_p <= r_p + PW'(1);
            end else begin
              r_k <= r_k + ADDR'(1);
            end
          end
        end
        S_FLUSH: begin
          if (i_en) begin
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_first = r_first;
  assign o_out_last  = r_last;
  assign o_out_pixel = r_pixel;
  assign o_done      = r_done;

endmodule

// File: tb/tb_fire4_squeeze_weight_sequencer.sv
// Bench for fire4_squeeze_weight_sequencer: two configurations (KLEN=4/NPIX=3 and KLEN=1/NPIX=5)
// driven with shared inputs and checked every cycle against a flat word-index model.
module tb_fire4_squeeze_weight_sequencer;

  logic clk = 1'b0;
  logic rst, start, abort, en;

  logic [2:0] a_addr;
  logic       a_valid, a_first, a_last, a_busy, a_done;
  logic [1:0] a_pix;
  logic [1:0] b_addr;
  logic       b_valid, b_first, b_last, b_busy, b_done;
  logic [2:0] b_pix;

  always #5 clk = ~clk;

  fire4_squeeze_weight_sequencer #(.ADDR(3), .KLEN(4), .NPIX(3)) u_a (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_en(en),
    .o_rom_addr(a_addr), .o_out_valid(a_valid), .o_out_first(a_first),
    .o_out_last(a_last), .o_out_pixel(a_pix), .o_busy(a_busy), .o_done(a_done)
  );

  fire4_squeeze_weight_sequencer #(.ADDR(2), .KLEN(1), .NPIX(5)) u_b (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_en(en),
    .o_rom_addr(b_addr), .o_out_valid(b_valid), .o_out_first(b_first),
    .o_out_last(b_last), .o_out_pixel(b_pix), .o_busy(b_busy), .o_done(b_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: pass described as a flat word index w in 0..KLEN*NPIX-1 (k = w%KLEN, p = w/KLEN)
  int KL[2] = '{4, 1};
  int NP[2] = '{3, 5};
  int m_mode[2];   // 0 idle, 1 running, 2 draining
  int m_w[2];
  int m_held[2];
  int m_valid[2], m_first[2], m_last[2], m_pix[2], m_done[2];

  int cnt_valid[2], cnt_busy[2], cnt_done[2];

  task automatic model_clear(input int i);
    m_mode[i] = 0; m_w[i] = 0; m_held[i] = 0;
    m_valid[i] = 0; m_first[i] = 0; m_last[i] = 0; m_pix[i] = 0; m_done[i] = 0;
  endtask

  function automatic int model_addr(input int i);
    if (m_mode[i] == 1 && en) return m_w[i] % KL[i];
    return m_held[i];
  endfunction

  task automatic model_step(input int i);
    int k;
    if (rst || abort) begin
      model_clear(i);
      return;
    end
    m_done[i] = (m_mode[i] == 2 && en) ? 1 : 0;
    case (m_mode[i])
      0: if (start) begin m_mode[i] = 1; m_w[i] = 0; end
      1: if (en) begin
        k = m_w[i] % KL[i];
        m_held[i]  = k;
        m_valid[i] = 1;
        m_first[i] = (k == 0);
        m_last[i]  = (k == KL[i] - 1);
        m_pix[i]   = m_w[i] / KL[i];
        m_w[i]++;
        if (m_w[i] == KL[i] * NP[i]) m_mode[i] = 2;
      end
      default: if (en) begin
        m_valid[i] = 0; m_first[i] = 0; m_last[i] = 0; m_mode[i] = 0;
      end
    endcase
  endtask

  task automatic cycle(input logic r, input logic s, input logic ab, input logic e);
    int pa, pb;
    @(negedge clk);
    rst = r; start = s; abort = ab; en = e;
    #1;
    chk("a_rom_addr", int'(a_addr), model_addr(0));
    chk("b_rom_addr", int'(b_addr), model_addr(1));
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    pa = int'(a_pix);
    pb = int'(b_pix);
    chk("a_valid", a_valid, m_valid[0]);
    chk("a_first", a_first, m_first[0]);
    chk("a_last",  a_last,  m_last[0]);
    chk("a_pixel", pa,      m_pix[0]);
    chk("a_busy",  a_busy,  m_mode[0] != 0);
    chk("a_done",  a_done,  m_done[0]);
    chk("b_valid", b_valid, m_valid[1]);
    chk("b_first", b_first, m_first[1]);
    chk("b_last",  b_last,  m_last[1]);
    chk("b_pixel", pb,      m_pix[1]);
    chk("b_busy",  b_busy,  m_mode[1] != 0);
    chk("b_done",  b_done,  m_done[1]);
    cnt_valid[0] += int'(a_valid); cnt_busy[0] += int'(a_busy); cnt_done[0] += int'(a_done);
    cnt_valid[1] += int'(b_valid); cnt_busy[1] += int'(b_busy); cnt_done[1] += int'(b_done);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      cnt_valid[i] = 0; cnt_busy[i] = 0; cnt_done[i] = 0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; en = 1'b1;
    model_clear(0);
    model_clear(1);
    clear_counts();
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);

    // Full pass with en=1; extra start pulses while both instances are busy
    clear_counts();
    cycle(0, 1, 0, 1);
    for (int c = 0; c < 20; c++) cycle(0, (c >= 1 && c <= 3), 0, 1);
    chk("a_valid_words", cnt_valid[0], 12);
    chk("a_busy_cycles", cnt_busy[0], 13);
    chk("a_done_pulses", cnt_done[0], 1);
    chk("b_valid_words", cnt_valid[1], 5);
    chk("b_busy_cycles", cnt_busy[1], 6);
    chk("b_done_pulses", cnt_done[1], 1);

    // Stall mid-pass, then resume to completion
    clear_counts();
    cycle(0, 1, 0, 1);
    for (int c = 0; c < 6; c++) cycle(0, 0, 0, 1);
    for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0);
    for (int c = 0; c < 12; c++) cycle(0, 0, 0, 1);
    chk("a_stall_done", cnt_done[0], 1);

    // Abort mid-pass, then restart; rst together with start mid-pass
    cycle(0, 1, 0, 1);
    for (int c = 0; c < 9; c++) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 0, 1);
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 1);
    cycle(1, 1, 0, 1);
    for (int c = 0; c < 3; c++) cycle(0, 0, 0, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++)
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
